bcd_countdown_timer: RTL

Two-digit BCD countdown timer that produces the ones and tens digits consumed by the seven-segment decoder stage. A one-second tick is derived from the system clock by an internal prescaler. A small FSM handles start, pause and clear pulses. When the count reaches 00 the timer freezes and flags completion.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/bcd_countdown_timer_if.sv | 17 +
 rtl/bcd_countdown_timer_tick_gen.sv | 37 +++
 rtl/bcd_countdown_timer.sv | 110 +++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer family.
// Holds the FSM state encoding, the BCD digit limit and a helper that
// decrements a two-digit BCD value. The seven-segment decoder stage and
// other timer variants import this package as well.
package timer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t PAUSE = 2'd2;
  localparam state_t DONE  = 2'd3;

  localparam int BCD_MAX = 9;

  // Decrement {tens, ones} by one second. The caller never asks for a
  // decrement of 00, so the tens borrow cannot underflow.
  function automatic logic [7:0] bcd_dec(input logic [3:0] tens, input logic [3:0] ones);
    if (ones != 4'd0) begin
      return {tens, ones - 4'd1};
    end
    return {tens - 4'd1, 4'(BCD_MAX)};
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle of the BCD countdown timer.
//   start, pause, clear : single-cycle command pulses (controller -> timer)
//   d0, d1              : ones / tens BCD digits      (timer -> controller)
//   running, done       : status flags                (timer -> controller)
// master = the controller side, slave = the timer itself.
interface bcd_countdown_timer_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic [3:0] d0;
  logic [3:0] d1;
  logic       running;
  logic       done;

  modport master (output start, pause, clear, input d0, d1, running, done);
  modport slave  (input start, pause, clear, output d0, d1, running, done);
endinterface

// File: rtl/bcd_countdown_timer_tick_gen.sv
// Prescaler producing the count-step tick for the countdown timer.
//   clk, rst : clock and asynchronous active-high reset
//   en       : low forces the prescaler to 0 (IDLE/DONE/clear)
//   hold     : freezes the prescaler and suppresses the tick (pause)
//   tick     : high in the cycle where the prescaler sits at TICK_DIV-1
// The counter is clog2(TICK_DIV) bits wide, never narrower than one bit,
// so TICK_DIV=1 yields a tick in every enabled cycle.
module tick_gen #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count_reg;
  logic         at_last;

  assign at_last = (count_reg == LAST);
  assign tick    = en & ~hold & at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (!en) begin
      count_reg <= '0;
    end else if (!hold) begin
      count_reg <= at_last ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of bcd_countdown_timer_if
//              (start/pause/clear pulses in; d0/d1/running/done out)
// Counts down from INIT_TENS:INIT_ONES once per TICK_DIV clocks while
// running, freezes at 00 and raises done. All outputs are registered.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 100_000_000,
  parameter int INIT_TENS = 3,
  parameter int INIT_ONES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_countdown_timer_if.slave  bus
);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("TICK_DIV must be at least 1");
  end
  if (INIT_TENS < 0 || INIT_TENS > BCD_MAX) begin : g_bad_tens
    $error("INIT_TENS must be a BCD digit 0..9");
  end
  if (INIT_ONES < 0 || INIT_ONES > BCD_MAX) begin : g_bad_ones
    $error("INIT_ONES must be a BCD digit 0..9");
  end

  localparam logic [3:0] INIT_T    = 4'(INIT_TENS);
  localparam logic [3:0] INIT_O    = 4'(INIT_ONES);
  localparam logic       INIT_ZERO = (INIT_TENS == 0) && (INIT_ONES == 0);

  state_t     state_reg, state_next;
  logic       running_reg, running_next;
  logic       done_reg, done_next;
  logic [3:0] d0_reg, d1_reg;
  logic       tick;
  logic       last_step;
  logic       presc_en, presc_hold;
  logic [7:0] dec_val;

  // Prescaler only advances in RUN; it keeps its value through PAUSE and
  // through a pause pulse in RUN, and is zeroed everywhere else.
  assign presc_en   = ((state_reg == RUN) || (state_reg == PAUSE)) && !bus.clear;
  assign presc_hold = (state_reg == PAUSE) || bus.pause;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (presc_en),
    .hold (presc_hold),
    .tick (tick)
  );

  assign last_step = tick && (d1_reg == 4'd0) && (d0_reg == 4'd1);
  assign dec_val   = bcd_dec(d1_reg, d0_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      running_reg <= running_next;
      done_reg    <= done_next;
    end
  end

  // Priority clear > pause > start in every state.
  always_comb begin
    state_next = state_reg;
    if (bus.clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (!bus.pause && bus.start) state_next = INIT_ZERO ? DONE : RUN;
        RUN:     if (bus.pause) state_next = PAUSE;
                 else if (last_step) state_next = DONE;
        PAUSE:   if (!bus.pause && bus.start) state_next = RUN;
        default: state_next = DONE;
      endcase
    end
  end

  // Status flags are registered copies of the upcoming state.
  always_comb begin
    running_next = (state_next == RUN);
    done_next    = (state_next == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_reg <= INIT_T;
      d0_reg <= INIT_O;
    end else if (bus.clear) begin
      d1_reg <= INIT_T;
      d0_reg <= INIT_O;
    end else if ((state_reg == RUN) && tick) begin
      d1_reg <= dec_val[7:4];
      d0_reg <= dec_val[3:0];
    end
  end

  assign bus.d0      = d0_reg;
  assign bus.d1      = d1_reg;
  assign bus.running = running_reg;
  assign bus.done    = done_reg;

endmodule
